// File: rtl/sram_bank_ctrl_pkg.sv
// Shared types and constants for the multi-bank SRAM controller.
// Optional burst support is enabled by defining SRAM_BANK_CTRL_BURST_EN.
package sram_bank_ctrl_pkg;

  localparam int DEF_NUM_BANKS = 5;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_RD_LAT    = 1;

  // RD_LAT is limited to 1..4, so the latency counter only needs to reach 3
  localparam int RD_LAT_MAX = 4;
  localparam int LAT_CNT_W  = $clog2(RD_LAT_MAX);
  localparam int BURST_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

endpackage

// File: rtl/sram_bank_ctrl_if.sv
// Request/response and SRAM-side bus of the bank controller.
// req_burst exists only when SRAM_BANK_CTRL_BURST_EN is defined.
interface sram_bank_ctrl_if
  import sram_bank_ctrl_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W
) ();

  logic                        req_read;
  logic                        req_write;
  logic [ADDR_W-1:0]           req_addr;
  logic [NUM_BANKS-1:0]        req_wmask;
  logic [NUM_BANKS*DATA_W-1:0] req_wdata;
`ifdef SRAM_BANK_CTRL_BURST_EN
  logic [BURST_W-1:0]          req_burst;
`endif
  logic                        req_ready;
  logic                        rsp_valid;
  logic [NUM_BANKS*DATA_W-1:0] rsp_rdata;
  logic                        read_enable;
  logic [NUM_BANKS-1:0]        write_enable;
  logic [ADDR_W-1:0]           s_addr;
  logic [NUM_BANKS*DATA_W-1:0] s_wdata;
  logic [NUM_BANKS*DATA_W-1:0] s_rdata;

  modport slave (
    input  req_read, req_write, req_addr, req_wmask, req_wdata,
`ifdef SRAM_BANK_CTRL_BURST_EN
    input  req_burst,
`endif
    output req_ready, rsp_valid, rsp_rdata,
    output read_enable, write_enable, s_addr, s_wdata,
    input  s_rdata
  );

  modport master (
    output req_read, req_write, req_addr, req_wmask, req_wdata,
`ifdef SRAM_BANK_CTRL_BURST_EN
    output req_burst,
`endif
    input  req_ready, rsp_valid, rsp_rdata,
    input  read_enable, write_enable, s_addr, s_wdata,
    output s_rdata
  );

endinterface

// File: rtl/sram_addr_gen.sv
// Loadable SRAM address register with wrap-around increment and a beat counter.
// A beat count of 0 is loaded as 1 so every operation has at least one beat.
module sram_addr_gen
  import sram_bank_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               load,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [BURST_W-1:0] load_beats,
  input  logic               step,
  output logic [ADDR_W-1:0]  addr,
  output logic               last
);

  logic [BURST_W-1:0] beats_left;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr       <= '0;
      beats_left <= '0;
    end else if (load) begin
      addr       <= load_addr;
      beats_left <= (load_beats == '0) ? BURST_W'(1) : load_beats;
    end else if (step) begin
      // Natural overflow gives the wrap from all-ones back to zero
      addr       <= addr + 1'b1;
      beats_left <= beats_left - 1'b1;
    end
  end

  assign last = (beats_left == BURST_W'(1));

endmodule

// File: rtl/sram_bank_ctrl.sv
// Controller for NUM_BANKS parallel SRAM banks sharing one address (IDLE/WRITE/READ FSM).
// Define SRAM_BANK_CTRL_BURST_EN to add multi-beat read/write bursts via req_burst.
module sram_bank_ctrl
  import sram_bank_ctrl_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input logic             clk,
  input logic             n_rst,
  sram_bank_ctrl_if.slave bus
);

  localparam int WORD_W = NUM_BANKS * DATA_W;
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(RD_LAT - 1);

  state_e state, state_nxt;

  logic [LAT_CNT_W-1:0] lat_cnt;
  logic                 read_enable_q;
  logic [NUM_BANKS-1:0] write_enable_q;
  logic [WORD_W-1:0]    s_wdata_q;
  logic [WORD_W-1:0]    rsp_rdata_q;
  logic                 rsp_valid_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [BURST_W-1:0]   beats;
  logic                 last_beat;
  logic                 accept_wr;
  logic                 accept_rd;
  logic                 lat_done;
  logic                 step;

`ifdef SRAM_BANK_CTRL_BURST_EN
  assign beats = bus.req_burst;
`else
  assign beats = BURST_W'(1);
`endif

  // A simultaneous read and write resolves to the write; the read is dropped
  assign accept_wr = (state == IDLE) && bus.req_write;
  assign accept_rd = (state == IDLE) && bus.req_read && !bus.req_write;
  assign lat_done  = (state == READ) && (lat_cnt == LAT_LAST);
  assign step      = ((state == WRITE) || lat_done) && !last_beat;

  sram_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (accept_wr | accept_rd),
    .load_addr  (bus.req_addr),
    .load_beats (beats),
    .step       (step),
    .addr       (addr_q),
    .last       (last_beat)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_wr)      state_nxt = WRITE;
        else if (accept_rd) state_nxt = READ;
      end
      WRITE:   if (last_beat)             state_nxt = IDLE;
      READ:    if (lat_done && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered strobes and data; each beat's strobe is set one edge ahead
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lat_cnt        <= '0;
      read_enable_q  <= 1'b0;
      write_enable_q <= '0;
      s_wdata_q      <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_wr) begin
            write_enable_q <= bus.req_wmask;
            s_wdata_q      <= bus.req_wdata;
          end else if (accept_rd) begin
            read_enable_q <= 1'b1;
            lat_cnt       <= '0;
          end
        end
        WRITE: begin
          if (last_beat) write_enable_q <= '0;
          else           s_wdata_q      <= bus.req_wdata;
        end
        READ: begin
          if (lat_done) begin
            rsp_rdata_q <= bus.s_rdata;
            rsp_valid_q <= 1'b1;
            lat_cnt     <= '0;
            if (last_beat) read_enable_q <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: begin
          read_enable_q  <= 1'b0;
          write_enable_q <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready    = (state == IDLE);
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.read_enable  = read_enable_q;
  assign bus.write_enable = write_enable_q;
  assign bus.s_addr       = addr_q;
  assign bus.s_wdata      = s_wdata_q;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed self-checking bench: one controller with RD_LAT=1 and one with RD_LAT=3,
// each with a behavioural SRAM that only presents valid data in the final latency cycle.
module tb_sram_bank_ctrl;
  localparam int NB = 5;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int WW = NB * DW;
  localparam logic [WW-1:0] GARBAGE = {5{16'hDEAD}};

  logic clk = 1'b0;
  logic n_rst1, n_rst3;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sram_bank_ctrl_if #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW)) if1 ();
  sram_bank_ctrl_if #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW)) if3 ();

  sram_bank_ctrl #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst1), .bus(if1));
  sram_bank_ctrl #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .n_rst(n_rst3), .bus(if3));

  // SRAM models
  logic [WW-1:0] mem1 [1<<AW];
  logic [WW-1:0] mem3 [1<<AW];
  logic          pl_en1, pl_en3;
  logic [AW-1:0] pl_addr;
  logic [WW-1:0] pl_data;
  int            re_cnt3;

  always @(posedge clk) begin
    if (pl_en1) mem1[pl_addr] <= pl_data;
    else for (int i = 0; i < NB; i++)
      if (if1.write_enable[i]) mem1[if1.s_addr][i*DW +: DW] <= if1.s_wdata[i*DW +: DW];
  end

  always @(posedge clk) begin
    if (pl_en3) mem3[pl_addr] <= pl_data;
    else for (int i = 0; i < NB; i++)
      if (if3.write_enable[i]) mem3[if3.s_addr][i*DW +: DW] <= if3.s_wdata[i*DW +: DW];
    if (!n_rst3 || !if3.read_enable) re_cnt3 <= 0;
    else re_cnt3 <= (re_cnt3 == 2) ? 0 : re_cnt3 + 1;
  end

  assign if1.s_rdata = if1.read_enable ? mem1[if1.s_addr] : GARBAGE;
  assign if3.s_rdata = (if3.read_enable && re_cnt3 == 2) ? mem3[if3.s_addr] : GARBAGE;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input bit to3, input logic [AW-1:0] a, input logic [WW-1:0] d);
    pl_addr = a;
    pl_data = d;
    if (to3) pl_en3 = 1'b1; else pl_en1 = 1'b1;
    tick();
    pl_en1 = 1'b0;
    pl_en3 = 1'b0;
  endtask

  localparam logic [WW-1:0] R4  = {16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100};
  localparam logic [WW-1:0] R30 = {16'h3004, 16'h3003, 16'h3002, 16'h3001, 16'h3000};
  localparam logic [WW-1:0] W30 = {16'h3004, 16'h3003, 16'h009A, 16'h3001, 16'h009A};
  localparam logic [WW-1:0] W7  = {16'h0074, 16'h0073, 16'h0072, 16'h0071, 16'h0070};
  localparam logic [WW-1:0] R1  = {16'h1104, 16'h1103, 16'h1102, 16'h1101, 16'h1100};

  initial begin
    n_rst1 = 1'b0; n_rst3 = 1'b0;
    pl_en1 = 1'b0; pl_en3 = 1'b0; pl_addr = '0; pl_data = '0;
    if1.req_read = 0; if1.req_write = 0; if1.req_addr = '0; if1.req_wmask = '0; if1.req_wdata = '0;
    if3.req_read = 0; if3.req_write = 0; if3.req_addr = '0; if3.req_wmask = '0; if3.req_wdata = '0;
`ifdef SRAM_BANK_CTRL_BURST_EN
    if1.req_burst = '0; if3.req_burst = '0;
`endif
    #3;
    check("rst_ready",  if1.req_ready, 1);
    check("rst_re",     if1.read_enable, 0);
    check("rst_we",     if1.write_enable, 0);
    check("rst_saddr",  if1.s_addr, 0);
    check("rst_swdata", if1.s_wdata, 0);
    check("rst_vld",    if1.rsp_valid, 0);
    check("rst_rdata",  if1.rsp_rdata, 0);
    tick();
    n_rst1 = 1'b1; n_rst3 = 1'b1;

    preload(0, 12'd4, R4);
    preload(0, 12'd30, R30);
    preload(0, 12'd7, {5{16'h7777}});
    preload(1, 12'd1, R1);

    // Single read, RD_LAT=1
    if1.req_read = 1; if1.req_addr = 12'd4;
    tick(); if1.req_read = 0;
    check("rd_re",     if1.read_enable, 1);
    check("rd_saddr",  if1.s_addr, 4);
    check("rd_busy",   if1.req_ready, 0);
    check("rd_novld",  if1.rsp_valid, 0);
    tick();
    check("rd_vld",    if1.rsp_valid, 1);
    check("rd_data",   if1.rsp_rdata, R4);
    check("rd_re_off", if1.read_enable, 0);
    check("rd_ready",  if1.req_ready, 1);
    tick();
    check("rd_vld_pulse", if1.rsp_valid, 0);
    check("rd_hold",      if1.rsp_rdata, R4);

    // Masked write then read back
    if1.req_write = 1; if1.req_addr = 12'd30; if1.req_wmask = 5'b00101; if1.req_wdata = {5{16'h009A}};
    tick(); if1.req_write = 0;
    check("wr_we",     if1.write_enable, 5'b00101);
    check("wr_saddr",  if1.s_addr, 30);
    check("wr_swdata", if1.s_wdata, {5{16'h009A}});
    check("wr_no_re",  if1.read_enable, 0);
    check("wr_busy",   if1.req_ready, 0);
    tick();
    check("wr_we_off", if1.write_enable, 0);
    check("wr_ready",  if1.req_ready, 1);
    if1.req_read = 1; if1.req_addr = 12'd30;
    tick(); if1.req_read = 0;
    tick();
    check("wr_rb_vld",  if1.rsp_valid, 1);
    check("wr_rb_data", if1.rsp_rdata, W30);

    // Zero-mask write still occupies the WRITE cycle
    if1.req_write = 1; if1.req_addr = 12'd30; if1.req_wmask = '0; if1.req_wdata = {5{16'hFFFF}};
    tick(); if1.req_write = 0;
    check("wr0_we",   if1.write_enable, 0);
    check("wr0_busy", if1.req_ready, 0);
    tick();
    check("wr0_ready", if1.req_ready, 1);

    // Read and write together: write wins, held read follows
    if1.req_read = 1; if1.req_write = 1; if1.req_addr = 12'd7; if1.req_wmask = 5'h1F; if1.req_wdata = W7;
    tick(); if1.req_write = 0;
    check("rw_we",    if1.write_enable, 5'h1F);
    check("rw_no_re", if1.read_enable, 0);
    tick();
    check("rw_ready", if1.req_ready, 1);
    check("rw_idle_re", if1.read_enable, 0);
    tick(); if1.req_read = 0;
    check("rw_re",    if1.read_enable, 1);
    check("rw_saddr", if1.s_addr, 7);
    tick();
    check("rw_vld",   if1.rsp_valid, 1);
    check("rw_data",  if1.rsp_rdata, W7);

    // RD_LAT=3 read
    if3.req_read = 1; if3.req_addr = 12'd1;
    tick(); if3.req_read = 0;
    for (int i = 1; i <= 3; i++) begin
      check("lat3_re",    if3.read_enable, 1);
      check("lat3_busy",  if3.req_ready, 0);
      check("lat3_novld", if3.rsp_valid, 0);
      tick();
    end
    check("lat3_re_off", if3.read_enable, 0);
    check("lat3_vld",    if3.rsp_valid, 1);
    check("lat3_ready",  if3.req_ready, 1);
    check("lat3_data",   if3.rsp_rdata, R1);

    // Reset in the second cycle of an RD_LAT=3 read
    tick();
    if3.req_read = 1; if3.req_addr = 12'd1;
    tick(); if3.req_read = 0;
    tick();
    #2 n_rst3 = 1'b0;
    #1;
    check("arst_ready",  if3.req_ready, 1);
    check("arst_re",     if3.read_enable, 0);
    check("arst_we",     if3.write_enable, 0);
    check("arst_saddr",  if3.s_addr, 0);
    check("arst_vld",    if3.rsp_valid, 0);
    check("arst_rdata",  if3.rsp_rdata, 0);
    tick();
    n_rst3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("arst_novld", if3.rsp_valid, 0);
      check("arst_nore",  if3.read_enable, 0);
    end
    if3.req_read = 1; if3.req_addr = 12'd1;
    tick(); if3.req_read = 0;
    tick(); tick(); tick();
    check("arst_rd_vld",  if3.rsp_valid, 1);
    check("arst_rd_data", if3.rsp_rdata, R1);

`ifdef SRAM_BANK_CTRL_BURST_EN
    preload(0, 12'hFFF, {5{16'hAF00}});
    preload(0, 12'h000, {5{16'hA000}});
    preload(0, 12'h001, {5{16'hA001}});
    if1.req_read = 1; if1.req_addr = 12'hFFF; if1.req_burst = 8'd3;
    tick(); if1.req_read = 0; if1.req_burst = '0;
    check("brd_saddr0", if1.s_addr, 12'hFFF);
    check("brd_re0",    if1.read_enable, 1);
    check("brd_busy0",  if1.req_ready, 0);
    tick();
    check("brd_saddr1", if1.s_addr, 12'h000);
    check("brd_vld1",   if1.rsp_valid, 1);
    check("brd_data1",  if1.rsp_rdata, {5{16'hAF00}});
    check("brd_busy1",  if1.req_ready, 0);
    tick();
    check("brd_saddr2", if1.s_addr, 12'h001);
    check("brd_vld2",   if1.rsp_valid, 1);
    check("brd_data2",  if1.rsp_rdata, {5{16'hA000}});
    tick();
    check("brd_vld3",   if1.rsp_valid, 1);
    check("brd_data3",  if1.rsp_rdata, {5{16'hA001}});
    check("brd_re_off", if1.read_enable, 0);
    check("brd_ready",  if1.req_ready, 1);

    if1.req_write = 1; if1.req_addr = 12'd40; if1.req_wmask = 5'h1F;
    if1.req_wdata = {5{16'h00AA}}; if1.req_burst = 8'd2;
    tick(); if1.req_write = 0; if1.req_burst = '0; if1.req_wdata = {5{16'h00BB}};
    check("bwr_we0",    if1.write_enable, 5'h1F);
    check("bwr_d0",     if1.s_wdata, {5{16'h00AA}});
    check("bwr_saddr0", if1.s_addr, 40);
    tick();
    check("bwr_we1",    if1.write_enable, 5'h1F);
    check("bwr_d1",     if1.s_wdata, {5{16'h00BB}});
    check("bwr_saddr1", if1.s_addr, 41);
    check("bwr_busy1",  if1.req_ready, 0);
    tick();
    check("bwr_we_off", if1.write_enable, 0);
    check("bwr_ready",  if1.req_ready, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
